// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with full/empty, programmable almost flags, half-full, fill level and
// sticky overflow/underflow capture. Flags are decoded from the registered pointers.
module sync_fifo_flags #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 1,
   parameter int unsigned AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clr,
   input  logic                  wr_enb,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_enb,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  half_full,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0] AfLevel   = AF_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AeLevel   = AE_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] HalfLevel = {2'b01, {(ADDR_WIDTH - 1){1'b0}}};

   logic [DATA_WIDTH-1:0] mem [Depth];

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  wr_accept;
   logic                  rd_accept;
   logic                  ptr_low_eq;
   logic                  ptr_msb_eq;

   assign ptr_low_eq = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   assign ptr_msb_eq = (wr_ptr_q[ADDR_WIDTH] == rd_ptr_q[ADDR_WIDTH]);

   always_comb begin
      full         = ptr_low_eq && !ptr_msb_eq;
      empty        = ptr_low_eq && ptr_msb_eq;
      level        = wr_ptr_q - rd_ptr_q;
      almost_full  = (level >= AfLevel);
      almost_empty = (level <= AeLevel);
      half_full    = (level >= HalfLevel);
   end

   // Accept decisions use the pre-edge flags: no write-through when full, no bypass when empty.
   assign wr_accept = wr_enb && !full && !clr;
   assign rd_accept = rd_enb && !empty && !clr;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
            rd_valid_d = 1'b1;
         end
         if (wr_enb && full) begin
            overflow_d = 1'b1;
         end
         if (rd_enb && empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags at default parameters (8-bit x 16 entries).
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rstn;
   logic       clr;
   logic       wr_enb;
   logic [7:0] wr_data;
   logic       rd_enb;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       half_full;
   logic [4:0] level;
   logic       overflow;
   logic       underflow;

   int checks   = 0;
   int failures = 0;

   sync_fifo_flags dut (
      .clk          (clk),
      .rstn         (rstn),
      .clr          (clr),
      .wr_enb       (wr_enb),
      .wr_data      (wr_data),
      .rd_enb       (rd_enb),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .half_full    (half_full),
      .level        (level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it in, then settle 1 time unit past the edge.
   task automatic step(input logic w, input logic [7:0] wd, input logic r, input logic c);
      wr_enb  = w;
      wr_data = wd;
      rd_enb  = r;
      clr     = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn    = 1'b0;
      clr     = 1'b0;
      wr_enb  = 1'b0;
      wr_data = 8'h00;
      rd_enb  = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_empty", 32'(empty), 1);
      chk("rst_aempty", 32'(almost_empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_afull", 32'(almost_full), 0);
      chk("rst_half", 32'(half_full), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_udf", 32'(underflow), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         chk("fill_level", 32'(level), 32'(i + 1));
         chk("fill_half", 32'(half_full), (i + 1 >= 8) ? 1 : 0);
         chk("fill_afull", 32'(almost_full), (i + 1 >= 15) ? 1 : 0);
         chk("fill_full", 32'(full), (i + 1 == 16) ? 1 : 0);
         chk("fill_aempty", 32'(almost_empty), (i + 1 <= 1) ? 1 : 0);
      end
      chk("fill_ovf_pre", 32'(overflow), 0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_level", 32'(level), 16);

      // Drain
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_valid", 32'(rd_valid), 1);
         chk("drain_data", 32'(rd_data), 32'(i));
         chk("drain_level", 32'(level), 32'(15 - i));
      end
      chk("drain_empty", 32'(empty), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_valid", 32'(rd_valid), 0);
      chk("idle_hold", 32'(rd_data), 32'h0F);
      chk("udf_pre", 32'(underflow), 0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_set", 32'(underflow), 1);
      chk("udf_valid", 32'(rd_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", 32'(overflow), 0);
      chk("clr_udf", 32'(underflow), 0);

      // Concurrent at level 5, 40 cycles, crossing pointer wrap
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      chk("conc_level0", 32'(level), 5);
      for (int k = 0; k < 40; k++) begin
         step(1'b1, 8'(8'h25 + k), 1'b1, 1'b0);
         chk("conc_level", 32'(level), 5);
         chk("conc_valid", 32'(rd_valid), 1);
         chk("conc_data", 32'(rd_data), 32'(8'h20 + k));
      end

      // Full with simultaneous write+read
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      chk("bnd_full", 32'(full), 1);
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("bnd_full_level", 32'(level), 15);
      chk("bnd_full_ovf", 32'(overflow), 1);
      chk("bnd_full_data", 32'(rd_data), 32'h40);
      chk("bnd_full_valid", 32'(rd_valid), 1);

      // Empty with simultaneous write+read
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("bnd_empty_level", 32'(level), 1);
      chk("bnd_empty_valid", 32'(rd_valid), 0);
      chk("bnd_empty_udf", 32'(underflow), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("bnd_empty_rd", 32'(rd_data), 32'h55);
      chk("bnd_empty_rdv", 32'(rd_valid), 1);

      // Flush with concurrent write; sticky underflow is still set from above
      for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      chk("fl_level9", 32'(level), 9);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("fl_level", 32'(level), 0);
      chk("fl_empty", 32'(empty), 1);
      chk("fl_udf", 32'(underflow), 0);
      chk("fl_ovf", 32'(overflow), 0);
      chk("fl_rd_hold", 32'(rd_data), 32'h55);

      // Async reset in the middle of a write burst
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rs_udf_pre", 32'(underflow), 1);
      for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      chk("rs_level9", 32'(level), 9);
      rstn = 1'b0;
      #1;
      chk("rs_level", 32'(level), 0);
      chk("rs_empty", 32'(empty), 1);
      chk("rs_udf", 32'(underflow), 0);
      chk("rs_rd_data", 32'(rd_data), 0);
      @(negedge clk);
      rstn = 1'b1;
      step(1'b1, 8'h99, 1'b0, 1'b0);
      chk("rs_resume_level", 32'(level), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rs_resume_data", 32'(rd_data), 32'h99);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
